// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor (d = a - b), LSB first.
//                One full-subtractor cell plus a borrow flip-flop. Reports
//                unsigned borrow, signed overflow and zero. Start/busy/done
//                handshake toward the calculator control FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int                c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_load;
    logic               w_run;
    logic               w_last;
    logic               w_ai;
    logic               w_bi;
    logic               w_diff;
    logic               w_borrow_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    // Operands are accepted whenever the unit is not busy (IDLE or DONE).
    assign w_run  = (r_state == c_S_RUN);
    assign w_load = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_last = w_run && (r_cnt == c_LAST);

    // Single full-subtractor cell on the current LSBs.
    assign w_ai         = r_sa[0];
    assign w_bi         = r_sb[0];
    assign w_diff       = w_ai ^ w_bi ^ r_borrow;
    assign w_borrow_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
    assign w_res_nxt    = {w_diff, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the last RUN edge is the one where the counter hits WIDTH.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start)  w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_last) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = start ? c_S_RUN : c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Serial datapath: load operands, shift one bit per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_load) begin
            r_sa     <= a;
            r_sb     <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (w_run) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res    <= w_res_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + c_ONE;
        end
    end

    // Result outputs update only on the completing edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_d    <= w_res_nxt;
            r_bout <= w_borrow_nxt;
            r_ovf  <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
            r_zero <= (w_res_nxt == '0);
        end
    end

    assign busy = w_run;
    assign done = (r_state == c_S_DONE);
    assign d    = r_d;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor. An arithmetic
//                reference model predicts busy/done/results every cycle;
//                directed cases pin literal results and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: countdown of remaining cycles plus the arithmetic result.
    bit           m_valid = 0;
    bit           m_active = 0;
    bit           m_done = 0;
    int           m_left = 0;
    logic [W-1:0] m_d = '0;
    bit           m_bout = 0, m_ovf = 0, m_zero = 0;
    logic [W-1:0] p_d;
    bit           p_bout, p_ovf, p_zero;

    always @(posedge clk) begin
        int sdiff;
        if (rst) begin
            m_valid  = 1;
            m_active = 0;
            m_done   = 0;
            m_d      = '0;
            m_bout   = 0;
            m_ovf    = 0;
            m_zero   = 0;
        end else begin
            m_done = 0;
            if (!m_active && start) begin
                m_active = 1;
                m_left   = W;
                p_d      = a - b;
                p_bout   = (a < b);
                sdiff    = int'($signed(a)) - int'($signed(b));
                p_ovf    = (sdiff > 127) || (sdiff < -128);
                p_zero   = (a == b);
            end else if (m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 0;
                    m_done   = 1;
                    m_d      = p_d;
                    m_bout   = p_bout;
                    m_ovf    = p_ovf;
                    m_zero   = p_zero;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("d",    32'(d),    32'(m_d));
            chk("bout", 32'(bout), 32'(m_bout));
            chk("ovf",  32'(ovf),  32'(m_ovf));
            chk("zero", 32'(zero), 32'(m_zero));
        end
    end

    // Counts negedges until done is seen; a missing pulse is a failure.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (done) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL done_timeout: got no done expected done within 30 cycles");
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] ed, input bit eb, input bit eo, input bit ez);
        int n;
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(n);
        chk("latency", 32'(n), 32'd9);
        chk("lit_d",    32'(d),    32'(ed));
        chk("lit_bout", 32'(bout), 32'(eb));
        chk("lit_ovf",  32'(ovf),  32'(eo));
        chk("lit_zero", 32'(zero), 32'(ez));
        @(posedge clk); #2;
    endtask

    initial begin
        int n;
        int ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d",    32'(d),    32'd0);
        @(posedge clk); #2;

        // Directed arithmetic cases.
        run_op(8'h05, 8'h03, 8'h02, 0, 0, 0);
        run_op(8'h03, 8'h05, 8'hFE, 1, 0, 0);
        run_op(8'h80, 8'h01, 8'h7F, 0, 1, 0);
        run_op(8'h7F, 8'hFF, 8'h80, 1, 1, 0);
        run_op(8'h2A, 8'h2A, 8'h00, 0, 0, 1);
        run_op(8'h00, 8'h00, 8'h00, 0, 0, 1);

        // start during RUN is ignored; results hold afterwards.
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(n);
        chk("ign_d", 32'(d), 32'h0F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_d",    32'(d),    32'h0F);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #2;

        // Back-to-back with start held high.
        a = 8'h09; b = 8'h04; start = 1'b1;
        @(posedge clk); #2 a = 8'h00; b = 8'h01;
        wait_done(n);
        chk("b2b_d0", 32'(d), 32'h05);
        @(posedge clk); #2 start = 1'b0;
        wait_done(n);
        chk("b2b_gap",  32'(n),    32'd9);
        chk("b2b_d1",   32'(d),    32'hFF);
        chk("b2b_bout", 32'(bout), 32'd1);
        @(posedge clk); #2;

        // Reset in the middle of an operation.
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_d",    32'(d),    32'd0);
        chk("mrst_bout", 32'(bout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 32'd0);
        @(posedge clk); #2;
        run_op(8'h33, 8'h11, 8'h22, 0, 0, 0);

        // Randomized operations, with ignored start pulses mid-run.
        for (int k = 0; k < 150; k++) begin
            a = W'($urandom); b = W'($urandom);
            if ((k % 10) == 0) b = a;
            start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #2 a = W'($urandom); b = W'($urandom); start = 1'b1;
                @(posedge clk); #2 start = 1'b0;
            end
            wait_done(n);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
